// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute-stage ALU driven by the decoder's 3-bit ALUControl code. An operation is
//   captured on the in_valid/in_ready handshake. Its result and NZCV flags stay
//   registered until the downstream stage takes them with out_ready.
//   Single-cycle ops: ADD, SUB, AND, XOR, SLT, SLTU.
//   SLL shifts by 1 bit per cycle.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   in_valid / in_ready   input handshake for ALUControl, SrcA, SrcB
//   ALUControl            000 ADD, 001 SUB, 010 AND, 011 ADD, 100 SLL,
//                         101 SLT, 110 SLTU, 111 XOR
//   SrcA, SrcB            operands; the SLL shift count is SrcB[SHAMT_W-1:0]
//   out_valid / out_ready output handshake for Result and the flags
//   Result                registered result
//   Zero, Negative        flags taken from Result
//   Carry, Overflow       flags from the adder; 0 for non-adder ops
//   busy                  high while an SLL is shifting
//
// state | meaning
// IDLE  | empty, ready for a new operation
// SHIFT | SLL in progress, one bit per cycle; input stalled
// DONE  | Result/flags valid, held until out_ready

module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_ADD2 = 3'b011;
    localparam logic [2:0] OP_SLL  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] cnt;

    logic               accept;
    logic               start_shift;
    logic               is_sub;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   b_op;
    logic [WIDTH-1:0]   add_sum;
    logic               add_c;
    logic               add_v;
    logic [WIDTH-1:0]   op_res;
    logic               op_c;
    logic               op_v;
    logic [WIDTH-1:0]   acc_shl;

    assign shamt       = SrcB[SHAMT_W-1:0];
    assign is_sub      = (ALUControl == OP_SUB);
    assign start_shift = (ALUControl == OP_SLL) && (shamt != '0);
    assign acc_shl     = {acc[WIDTH-2:0], 1'b0};
    assign out_valid   = (state == DONE);
    assign busy        = (state == SHIFT);

    // SUB is A + ~B + 1. The adder carry-out is therefore the no-borrow flag.
    assign b_op = is_sub ? ~SrcB : SrcB;
    assign {add_c, add_sum} = {1'b0, SrcA} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    assign add_v = ~(SrcA[WIDTH-1] ^ b_op[WIDTH-1]) & (add_sum[WIDTH-1] ^ SrcA[WIDTH-1]);

    always_comb begin
        op_res = '0;
        op_c   = 1'b0;
        op_v   = 1'b0;
        case (ALUControl)
            OP_ADD, OP_SUB, OP_ADD2: begin
                op_res = add_sum;
                op_c   = add_c;
                op_v   = add_v;
            end
            OP_AND:  op_res = SrcA & SrcB;
            OP_XOR:  op_res = SrcA ^ SrcB;
            OP_SLL:  op_res = SrcA;   // reached only for a zero shift count
            OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_SLTU: op_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
            default: op_res = '0;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        accept    = in_valid && in_ready;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = start_shift ? SHIFT : DONE;
            end
            SHIFT: begin
                if (cnt == SHAMT_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                if (accept)         state_nxt = start_shift ? SHIFT : DONE;
                else if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            Result   <= '0;
            Zero     <= 1'b0;
            Negative <= 1'b0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
        end else if (accept) begin
            if (start_shift) begin
                acc <= SrcA;
                cnt <= shamt;
            end else begin
                Result   <= op_res;
                Zero     <= (op_res == '0);
                Negative <= op_res[WIDTH-1];
                Carry    <= op_c;
                Overflow <= op_v;
            end
        end else if (state == SHIFT) begin
            acc <= acc_shl;
            cnt <= cnt - SHAMT_W'(1);
            // Result is published only on the last shift step.
            if (cnt == SHAMT_W'(1)) begin
                Result   <= acc_shl;
                Zero     <= (acc_shl == '0);
                Negative <= acc_shl[WIDTH-1];
                Carry    <= 1'b0;
                Overflow <= 1'b0;
            end
        end
    end

endmodule
